// File: rtl/dvp_pixel_packer.sv
// dvp_pixel_packer: packs DVP byte pairs into RGB565 pixels and adds AXI4-Stream
// video framing. TUSER marks the start of a frame and TLAST marks the end of a line.
// Pixels leave through a first-word-fall-through FIFO toward a backpressured consumer.
module dvp_pixel_packer #(
   parameter int LINE_PIXELS = 640,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   input  logic        s_tlast,
   output logic [15:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tuser,
   output logic        m_tlast,
   output logic        overflow,
   output logic        frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
   localparam logic [CW-1:0] LAST_PIX = CW'(LINE_PIXELS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {SYNC, RUN, DROP} state_t;

   state_t          state_q;
   logic            phase_q;
   logic [7:0]      hi_q;
   logic [CW-1:0]   pix_cnt_q;
   logic            sof_pend_q;
   logic            overflow_q;
   logic            frame_err_q;

   // FIFO entry layout: {tuser, tlast, data[15:0]}
   logic [17:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;

   logic            pop;
   logic            line_end;
   logic            push_req;
   logic            push_ok;
   logic [17:0]     push_entry;
   logic [17:0]     head;

   // Push/pop qualification; a pop frees a slot for a push in the same cycle
   always_comb begin
      pop        = (count_q != '0) & m_tready;
      line_end   = (pix_cnt_q == LAST_PIX);
      push_req   = (state_q == RUN) & s_tvalid & phase_q;
      push_entry = {sof_pend_q, line_end | s_tlast, hi_q, s_tdata};
      push_ok    = push_req & ((count_q < FULL_CNT) | pop);
   end

   // Framing state machine: byte pairing, line/frame tracking, error flags
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= SYNC;
         phase_q     <= 1'b0;
         hi_q        <= '0;
         pix_cnt_q   <= '0;
         sof_pend_q  <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            SYNC, DROP: begin
               if (s_tvalid && s_tlast) begin
                  state_q    <= RUN;
                  sof_pend_q <= 1'b1;
                  phase_q    <= 1'b0;
                  pix_cnt_q  <= '0;
               end
            end
            RUN: begin
               if (s_tvalid) begin
                  if (!phase_q) begin
                     if (s_tlast) begin
                        // Frame ended on a lone first byte: drop it
                        frame_err_q <= 1'b1;
                        sof_pend_q  <= 1'b1;
                        pix_cnt_q   <= '0;
                     end else begin
                        hi_q    <= s_tdata;
                        phase_q <= 1'b1;
                     end
                  end else begin
                     phase_q <= 1'b0;
                     if (push_ok) begin
                        sof_pend_q <= 1'b0;
                        pix_cnt_q  <= line_end ? '0 : pix_cnt_q + CW'(1);
                     end else begin
                        overflow_q <= 1'b1;
                        state_q    <= DROP;
                     end
                     // Frame end overrides the counter/sof updates above
                     if (s_tlast) begin
                        sof_pend_q <= 1'b1;
                        pix_cnt_q  <= '0;
                        if (!line_end) frame_err_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end

   // Output FIFO storage and occupancy
   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Head entry drives the stream; fields read zero when the FIFO is empty
   always_comb begin
      head      = mem_q[rd_ptr_q];
      m_tvalid  = (count_q != '0);
      m_tuser   = m_tvalid & head[17];
      m_tlast   = m_tvalid & head[16];
      m_tdata   = m_tvalid ? head[15:0] : '0;
      overflow  = overflow_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Directed bench for dvp_pixel_packer with LINE_PIXELS=4 and FIFO_DEPTH=4.
module tb_dvp_pixel_packer;

   localparam int LP = 4;
   localparam int FD = 4;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        m_tready = 1'b0;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tuser;
   logic        m_tlast;
   logic        overflow;
   logic        frame_err;

   int          nvec = 0;
   int          nmis = 0;
   int          ferr_cnt = 0;
   logic [17:0] cap [$];

   always #5 pclk = ~pclk;

   dvp_pixel_packer #(.LINE_PIXELS(LP), .FIFO_DEPTH(FD)) dut (
      .pclk(pclk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .overflow(overflow), .frame_err(frame_err)
   );

   typedef struct {
      logic [7:0]  d;
      logic        v;
      logic        l;
      logic [20:0] exp;  // {valid, user, last, overflow, frame_err, data}
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One input cycle: drive at the falling edge, log the pop the next rising edge performs
   task automatic cyc(input logic [7:0] d, input logic v, input logic l, input logic r);
      @(negedge pclk);
      s_tdata  = d;
      s_tvalid = v;
      s_tlast  = l;
      m_tready = r;
      if (!rst) begin
         if (m_tvalid && m_tready) cap.push_back({m_tuser, m_tlast, m_tdata});
         if (frame_err) ferr_cnt++;
      end
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, r);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cap.delete();
      ferr_cnt = 0;
   endtask

   task automatic check_cap(input string name, input int idx, input logic [17:0] exp);
      logic [31:0] got;
      got = (idx < cap.size()) ? {14'h0, cap[idx]} : 32'hFFFF_FFFF;
      check(name, got, {14'h0, exp});
   endtask

   function automatic logic [20:0] outs();
      return {m_tvalid, m_tuser, m_tlast, overflow, frame_err, m_tdata};
   endfunction

   initial begin
      tbl[0] = '{8'hAA, 1'b1, 1'b0, 21'h0};
      tbl[1] = '{8'hBB, 1'b1, 1'b0, 21'h0};
      tbl[2] = '{8'hCC, 1'b1, 1'b1, 21'h0};
      tbl[3] = '{8'h12, 1'b1, 1'b0, 21'h0};
      tbl[4] = '{8'h34, 1'b1, 1'b0, 21'h0};
      tbl[5] = '{8'h56, 1'b1, 1'b0, {5'b11000, 16'h1234}};
      tbl[6] = '{8'h78, 1'b1, 1'b0, 21'h0};
      tbl[7] = '{8'h00, 1'b0, 1'b0, {5'b10000, 16'h5678}};
      tbl[8] = '{8'h00, 1'b0, 1'b0, 21'h0};

      // Sync/align: cycle-by-cycle table
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].d, tbl[i].v, tbl[i].l, 1'b1);
         check($sformatf("align_row%0d", i), {11'h0, outs()}, {11'h0, tbl[i].exp});
      end

      // Line/frame framing: two full lines ending on s_tlast
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) cyc(8'(8'h10 + k), 1'b1, (k == 15), 1'b1);
      idle(4, 1'b1);
      check("frame_count", cap.size(), 8);
      for (int p = 0; p < 8; p++)
         check_cap($sformatf("frame_pix%0d", p), p,
                   {(p == 0), (p == 3 || p == 7), 8'(8'h10 + 2*p), 8'(8'h11 + 2*p)});
      check("frame_ferr", ferr_cnt, 0);

      // Malformed end: 5-byte frame
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cyc(8'(8'hA0 + k), 1'b1, (k == 4), 1'b1);
      cyc(8'hB0, 1'b1, 1'b0, 1'b1);
      cyc(8'hB1, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check("odd_count", cap.size(), 3);
      check_cap("odd_pix0", 0, {2'b10, 16'hA0A1});
      check_cap("odd_pix1", 1, {2'b00, 16'hA2A3});
      check_cap("odd_next_sof", 2, {2'b10, 16'hB0B1});
      check("odd_ferr", ferr_cnt, 1);

      // Malformed end: 6-byte frame, short line
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) cyc(8'(8'hC0 + k), 1'b1, (k == 5), 1'b1);
      idle(3, 1'b1);
      check("short_count", cap.size(), 3);
      check_cap("short_pix0", 0, {2'b10, 16'hC0C1});
      check_cap("short_pix2", 2, {2'b01, 16'hC4C5});
      check("short_ferr", ferr_cnt, 1);

      // Backpressure and overflow
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cyc(8'(8'h40 + i), 1'b1, (i == 11), 1'b0);
         if (i == 8)  check("ovf_before", overflow, 0);
         if (i == 10) check("ovf_after", overflow, 1);
         if (i == 11) check("ovf_head_hold", {m_tvalid, m_tdata}, {1'b1, 16'h4041});
      end
      idle(6, 1'b1);
      cyc(8'h50, 1'b1, 1'b0, 1'b1);
      cyc(8'h51, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check("ovf_count", cap.size(), 5);
      check_cap("ovf_pix0", 0, {2'b10, 16'h4041});
      check_cap("ovf_pix3", 3, {2'b01, 16'h4647});
      check_cap("ovf_next_sof", 4, {2'b10, 16'h5051});
      check("ovf_sticky", overflow, 1);

      // Full FIFO with a pop on the push cycle
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc(8'(8'h60 + i), 1'b1, 1'b0, (i == 9));
      idle(6, 1'b1);
      check("full_count", cap.size(), 5);
      for (int p = 0; p < 5; p++)
         check_cap($sformatf("full_pix%0d", p), p,
                   {(p == 0), (p == 3), 8'(8'h60 + 2*p), 8'(8'h61 + 2*p)});
      check("full_ovf", overflow, 0);

      // Mid-frame reset
      do_reset();
      cyc(8'hEE, 1'b1, 1'b1, 1'b0);
      cyc(8'hA0, 1'b1, 1'b0, 1'b0);
      cyc(8'hA1, 1'b1, 1'b0, 1'b0);
      cyc(8'hA2, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(8'hA3, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(8'h00, 1'b0, 1'b0, 1'b1);
      check("rst_outputs", {11'h0, outs()}, 32'h0);
      for (int k = 0; k < 4; k++) cyc(8'(8'hB0 + k), 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);
      check("rst_no_output", cap.size(), 0);
      cyc(8'hEE, 1'b1, 1'b1, 1'b1);
      cyc(8'hD0, 1'b1, 1'b0, 1'b1);
      cyc(8'hD1, 1'b1, 1'b0, 1'b1);
      idle(3, 1'b1);
      check("rst_count", cap.size(), 1);
      check_cap("rst_pix0", 0, {2'b10, 16'hD0D1});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/dvp_pixel_packer.md
# dvp_pixel_packer

Downstream stage of the DVP byte receiver, clocked in the `pclk` domain. It takes the receiver's 8-bit byte stream (TLAST marks frame end, no backpressure) and packs byte pairs into 16-bit RGB565 pixels. It also generates AXI4-Stream video framing: TUSER on start of frame, TLAST on end of line. Pixels go out through a small first-word-fall-through FIFO to a backpressured consumer (VDMA or video pipeline).

## Interface
Parameters:
- `LINE_PIXELS`, default 640: pixels per line; range 2..4095.
- `FIFO_DEPTH`, default 16: output FIFO entries; power of two, at least 4.

Ports:
- `pclk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_tdata` in 8: input byte.
- `s_tvalid` in 1: byte valid; there is no `s_tready`, so every valid byte must be consumed that cycle.
- `s_tlast` in 1: qualified by `s_tvalid`; this byte is the last of the frame.
- `m_tdata` out 16: pixel, `{first_byte, second_byte}`.
- `m_tvalid` out 1: FIFO head valid.
- `m_tready` in 1: consumer ready.
- `m_tuser` out 1: first pixel of frame.
- `m_tlast` out 1: last pixel of line.
- `overflow` out 1: sticky; a pixel was lost to a full FIFO. Cleared only by `rst`.
- `frame_err` out 1: one-cycle pulse on a malformed frame end.

## Operation
- State machine with states SYNC, RUN and DROP. Reset state is SYNC.
- **SYNC:** discard all bytes. On `s_tvalid & s_tlast`, go to RUN with `sof_pend=1`, `phase=0` and `pix_cnt=0`.
- **RUN, byte handling:**
  - On a valid byte with `phase=0`: store it in `hi_reg` and set `phase=1`.
  - On a valid byte with `phase=1`: form pixel `{hi_reg, s_tdata}`, set `phase=0`, then push the pixel.
- **RUN, pixel push:** each entry is `{tuser=sof_pend, tlast=(pix_cnt==LINE_PIXELS-1) | s_tlast, data}`.
  - After a push, clear `sof_pend`.
  - `pix_cnt` increments and wraps to 0 after `LINE_PIXELS-1`.
- **Frame end in RUN:** on `s_tlast`, set `sof_pend=1` and `pix_cnt=0`.
  - If `s_tlast` arrives on a `phase=0` byte, the byte is discarded, `phase` stays 0 and `frame_err` pulses.
  - If `s_tlast` arrives on a pixel completing with `pix_cnt != LINE_PIXELS-1`, the pixel is still pushed with `tlast=1` and `frame_err` pulses.
- **Overflow:** the FIFO accepts a push when `count < FIFO_DEPTH`, or when a pop happens in the same cycle.
  - If a push is refused, the pixel is dropped, `overflow` is set and the state goes to DROP.
- **DROP:** discard bytes until `s_tvalid & s_tlast`, then go to RUN with `sof_pend=1`, `phase=0` and `pix_cnt=0`.
- **FIFO:** a pop occurs on `m_tvalid & m_tready`. Output fields always come from the head entry and hold stable while `m_tvalid & !m_tready`.
- **Reset:** clears FIFO contents, `count`, `phase`, `pix_cnt`, `sof_pend`, `overflow` and state. Reset mid-frame returns to SYNC, so the partial frame is never emitted.

## Timing
- Reset values:
  - `m_tvalid=0`, `m_tuser=0`, `m_tlast=0`, `m_tdata=0`.
  - `overflow=0`, `frame_err=0`.
- Latency: if the second byte is accepted in cycle N, the FIFO write happens at the edge ending N and `m_tvalid=1` in cycle N+1 (empty FIFO case).
- `frame_err` is registered and asserted in cycle N+1 for an error byte in cycle N.
- Throughput: one pixel per 2 input bytes; pops can run every cycle.
- Simultaneous push and pop:
  - When full: both happen and `count` is unchanged.
  - When empty: the push lands, the pop does not occur, and `m_tvalid` rises next cycle.
- The `s_tlast` byte in SYNC or DROP is consumed by that state; bytes from the next cycle onward are in RUN.

## Test plan
- **Sync/align:** reset, then 3 junk bytes with the last carrying `s_tlast`, then bytes 0x12,0x34,0x56,0x78 → pixels 0x1234 (`m_tuser=1`) and 0x5678 (`m_tuser=0`); no output before the `s_tlast`.
- **Line/frame framing:** `LINE_PIXELS=4`, 2 full lines, `m_tready=1`, last byte carrying `s_tlast` → `m_tlast` on pixels 3 and 7, `m_tuser` only on pixel 0, `frame_err` never asserted.
- **Malformed ends:**
  - Frame of 5 bytes → 2 pixels, the 5th byte dropped, `frame_err` pulses once.
  - Frame of 6 bytes with `LINE_PIXELS=4` → pixel 2 carries `m_tlast=1` and `frame_err` pulses.
- **Backpressure/overflow:** `FIFO_DEPTH=4`, `m_tready=0`, 12 bytes → 4 pixels held stable, `overflow=1` after the 5th pixel. Then release `m_tready`: exactly 4 pixels emitted; next frame starts with `m_tuser=1`.
- **Full with concurrent pop:** FIFO full, `m_tready=1` on the push cycle → no pixel loss, `overflow` stays 0, and pixel order is preserved.
- **Mid-frame reset:** assert `rst` for 1 cycle mid-line → all outputs 0 next cycle, FIFO empty, nothing emitted until after the next `s_tlast`.
